// File: rtl/fetch_ctrl_if.sv
// Shared types and the fetch-side bus bundle: redirect, icache request/response,
// branch-predictor lookup and instruction-buffer write port.
package fetch_ctrl_pkg;

    typedef logic [3:0] exception_t;

    // Per-request metadata held until the matching icache response returns
    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  size;
        logic        taken1;
        logic        taken2;
        logic [31:0] target;
    } fetch_meta_t;

endpackage

interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic        flush;
    logic [31:0] flush_target;

    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;

    logic        bp_taken1;
    logic        bp_taken2;
    logic [31:0] bp_target;

    logic        resp_valid;
    logic [31:0] resp_inst1;
    logic [31:0] resp_inst2;
    logic        resp_have_exception;
    exception_t  resp_exception_type;

    logic [1:0]  ibuf_input_size;
    logic [31:0] ibuf_pc1;
    logic [31:0] ibuf_inst1;
    logic        ibuf_pred_taken1;
    logic [31:0] ibuf_pred_target1;
    logic        ibuf_have_exception1;
    exception_t  ibuf_exception_type1;
    logic [31:0] ibuf_pc2;
    logic [31:0] ibuf_inst2;
    logic        ibuf_pred_taken2;
    logic [31:0] ibuf_pred_target2;

    logic [1:0]  consume_inst;

    modport master (
        input  flush, flush_target,
        output req_valid, req_pc,
        input  req_ready,
        input  bp_taken1, bp_taken2, bp_target,
        input  resp_valid, resp_inst1, resp_inst2, resp_have_exception, resp_exception_type,
        output ibuf_input_size,
        output ibuf_pc1, ibuf_inst1, ibuf_pred_taken1, ibuf_pred_target1,
        output ibuf_have_exception1, ibuf_exception_type1,
        output ibuf_pc2, ibuf_inst2, ibuf_pred_taken2, ibuf_pred_target2,
        input  consume_inst
    );

    modport slave (
        output flush, flush_target,
        input  req_valid, req_pc,
        output req_ready,
        output bp_taken1, bp_taken2, bp_target,
        output resp_valid, resp_inst1, resp_inst2, resp_have_exception, resp_exception_type,
        input  ibuf_input_size,
        input  ibuf_pc1, ibuf_inst1, ibuf_pred_taken1, ibuf_pred_target1,
        input  ibuf_have_exception1, ibuf_exception_type1,
        input  ibuf_pc2, ibuf_inst2, ibuf_pred_taken2, ibuf_pred_target2,
        output consume_inst
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: credit-throttled 2-wide icache requests, in-order response
// pairing with request metadata, and flush handling with stale-response drop.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int unsigned IBUF_DEPTH      = 8,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    localparam int unsigned OCC_W = $clog2(IBUF_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned SUM_W = OCC_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] res_q, res_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] stale_q, stale_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    fetch_meta_t      meta_q [MAX_OUTSTANDING];

    logic [1:0]       req_size_c;
    logic [SUM_W-1:0] fill_c;
    logic             room_c;
    logic             req_valid_c;
    logic             accept_c;
    logic [31:0]      next_pc_c;
    fetch_meta_t      push_c;
    fetch_meta_t      head_c;
    logic             resp_write_c;
    logic [1:0]       write_size_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request generation: size, credit check and predicted next PC
    always_comb begin
        req_size_c = fetch_pc_q[2] ? 2'd1 : 2'd2;
        if (bus.bp_taken1) begin
            req_size_c = 2'd1;
        end

        // Always reserve two slots so a later size change never overflows the buffer
        fill_c      = SUM_W'(occ_q) + SUM_W'(res_q) + SUM_W'(2);
        room_c      = (fill_c <= SUM_W'(IBUF_DEPTH));
        req_valid_c = !reset && !bus.flush && (out_q < OUT_W'(MAX_OUTSTANDING)) && room_c;
        accept_c    = req_valid_c && bus.req_ready;

        if (bus.bp_taken1) begin
            next_pc_c = bus.bp_target;
        end else if (bus.bp_taken2 && (req_size_c == 2'd2)) begin
            next_pc_c = bus.bp_target;
        end else begin
            next_pc_c = {fetch_pc_q[31:3] + 29'd1, 3'b000};
        end

        push_c.pc     = fetch_pc_q;
        push_c.size   = req_size_c;
        push_c.taken1 = bus.bp_taken1;
        push_c.taken2 = bus.bp_taken2 && (req_size_c == 2'd2);
        push_c.target = bus.bp_target;
    end

    // Response pairing: only non-stale responses outside flush/reset reach the buffer
    always_comb begin
        head_c       = meta_q[rd_ptr_q];
        resp_write_c = bus.resp_valid && !reset && !bus.flush && (stale_q == '0);
        write_size_c = resp_write_c ? head_c.size : 2'd0;
    end

    assign bus.req_valid            = req_valid_c;
    assign bus.req_pc               = fetch_pc_q;
    assign bus.ibuf_input_size      = write_size_c;
    assign bus.ibuf_pc1             = head_c.pc;
    assign bus.ibuf_pc2             = head_c.pc + 32'd4;
    assign bus.ibuf_inst1           = bus.resp_inst1;
    assign bus.ibuf_inst2           = bus.resp_inst2;
    assign bus.ibuf_pred_taken1     = head_c.taken1;
    assign bus.ibuf_pred_taken2     = head_c.taken2;
    assign bus.ibuf_pred_target1    = head_c.target;
    assign bus.ibuf_pred_target2    = head_c.target;
    assign bus.ibuf_have_exception1 = bus.resp_have_exception;
    assign bus.ibuf_exception_type1 = bus.resp_exception_type;

    // Next-state: reset, then flush, then normal request/response accounting
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        occ_d      = occ_q;
        res_d      = res_q;
        out_d      = out_q;
        stale_d    = stale_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (reset) begin
            fetch_pc_d = RESET_PC;
            occ_d      = '0;
            res_d      = '0;
            out_d      = '0;
            stale_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else if (bus.flush) begin
            // Everything still in flight becomes stale; a response this cycle is discarded
            fetch_pc_d = bus.flush_target;
            occ_d      = '0;
            res_d      = '0;
            out_d      = out_q - OUT_W'(bus.resp_valid);
            stale_d    = out_q - OUT_W'(bus.resp_valid);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (accept_c) begin
                fetch_pc_d = next_pc_c;
                wr_ptr_d   = ptr_inc(wr_ptr_q);
            end
            if (resp_write_c) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (bus.resp_valid && (stale_q != '0)) begin
                stale_d = stale_q - OUT_W'(1);
            end
            out_d = out_q + OUT_W'(accept_c) - OUT_W'(bus.resp_valid);
            res_d = res_q + (accept_c ? OCC_W'(2) : OCC_W'(0))
                          - (resp_write_c ? OCC_W'(2) : OCC_W'(0));
            occ_d = occ_q + OCC_W'(write_size_c) - OCC_W'(bus.consume_inst);
        end
    end

    always_ff @(posedge clk) begin
        fetch_pc_q <= fetch_pc_d;
        occ_q      <= occ_d;
        res_q      <= res_d;
        out_q      <= out_d;
        stale_q    <= stale_d;
        rd_ptr_q   <= rd_ptr_d;
        wr_ptr_q   <= wr_ptr_d;
        if (accept_c) begin
            meta_q[wr_ptr_q] <= push_c;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, flush corner sequences, a
// steady-state stream, and a randomized run against a queue-based model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int DEPTH   = 8;
    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .RESET_PC       (RESET_PC),
        .IBUF_DEPTH     (DEPTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h5a5a_0f0f;
    endfunction

    task automatic drive(input logic rst, input logic fl, input logic [31:0] ftgt,
                         input logic rdy, input logic rsp, input logic [31:0] i1,
                         input logic [31:0] i2, input logic exc, input exception_t et,
                         input logic [1:0] cons, input logic t1, input logic t2,
                         input logic [31:0] btgt);
        reset                   = rst;
        bus.flush               = fl;
        bus.flush_target        = ftgt;
        bus.req_ready           = rdy;
        bus.resp_valid          = rsp;
        bus.resp_inst1          = i1;
        bus.resp_inst2          = i2;
        bus.resp_have_exception = exc;
        bus.resp_exception_type = et;
        bus.consume_inst        = cons;
        bus.bp_taken1           = t1;
        bus.bp_taken2           = t2;
        bus.bp_target           = btgt;
    endtask

    task automatic reset_cycle(input string tag);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        #1;
        chk($sformatf("%s.rst_req_valid", tag), 32'(bus.req_valid), 32'h0);
        chk($sformatf("%s.rst_ibuf_size", tag), 32'(bus.ibuf_input_size), 32'h0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        flush;
        logic [31:0] ftgt;
        logic        ready;
        logic        resp;
        logic [1:0]  consume;
        logic        t1;
        logic        t2;
        logic [31:0] btgt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [1:0]  e_size;
        logic [31:0] e_pc1;
        logic        e_t1;
        logic        e_t2;
    } vec_t;

    function automatic vec_t mk(input logic fl, input logic [31:0] ftgt, input logic rdy,
                                input logic rsp, input logic [1:0] cons, input logic t1,
                                input logic t2, input logic [31:0] btgt, input logic ev,
                                input logic [31:0] epc, input logic [1:0] esz,
                                input logic [31:0] epc1, input logic et1, input logic et2);
        vec_t v;
        v.flush = fl;  v.ftgt = ftgt;  v.ready = rdy;  v.resp = rsp;  v.consume = cons;
        v.t1 = t1;  v.t2 = t2;  v.btgt = btgt;  v.e_valid = ev;  v.e_pc = epc;
        v.e_size = esz;  v.e_pc1 = epc1;  v.e_t1 = et1;  v.e_t2 = et2;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(1'b0, v.flush, v.ftgt, v.ready, v.resp, 32'h0bad_0001, 32'h0bad_0002,
              1'b0, 4'h0, v.consume, v.t1, v.t2, v.btgt);
        #1;
        chk($sformatf("%s.req_valid", tag), 32'(bus.req_valid), 32'(v.e_valid));
        if (v.e_valid) chk($sformatf("%s.req_pc", tag), bus.req_pc, v.e_pc);
        chk($sformatf("%s.ibuf_size", tag), 32'(bus.ibuf_input_size), 32'(v.e_size));
        if (v.e_size != 2'd0) begin
            chk($sformatf("%s.ibuf_pc1", tag), bus.ibuf_pc1, v.e_pc1);
            chk($sformatf("%s.ibuf_pc2", tag), bus.ibuf_pc2, v.e_pc1 + 32'd4);
            chk($sformatf("%s.ibuf_inst1", tag), bus.ibuf_inst1, 32'h0bad_0001);
            chk($sformatf("%s.pred_taken1", tag), 32'(bus.ibuf_pred_taken1), 32'(v.e_t1));
            chk($sformatf("%s.pred_taken2", tag), 32'(bus.ibuf_pred_taken2), 32'(v.e_t2));
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [31:0] pc;
        int          size;
        logic        t1;
        logic        t2;
        logic [31:0] tgt;
    } meta_t;

    typedef struct {
        logic [31:0] pc;
        int          due;
    } ic_t;

    logic [31:0] m_pc;
    int          m_occ, m_res, m_out, m_stale;
    meta_t       m_meta[$];
    ic_t         ic[$];
    int          cyc;

    task automatic model_reset();
        m_pc = RESET_PC;  m_occ = 0;  m_res = 0;  m_out = 0;  m_stale = 0;
        m_meta.delete();
        ic.delete();
    endtask

    task automatic rand_cycle();
        logic        do_rst, fl, rdy, rsp, t1, t2, exc, ev, acc;
        logic [31:0] r, ftgt, btgt, i1, i2;
        exception_t  et;
        logic [1:0]  cons;
        int          esz, sz, cmax;
        meta_t       hd, nm;
        ic_t         ne;

        do_rst = ($urandom_range(0, 299) == 0);
        fl     = !do_rst && ($urandom_range(0, 19) == 0);
        rdy    = ($urandom_range(0, 3) != 0);
        rsp    = !do_rst && (ic.size() > 0) && ($urandom_range(0, 3) != 0);
        if (rsp && ic[0].due > cyc) rsp = 1'b0;
        t1     = ($urandom_range(0, 7) == 0);
        t2     = ($urandom_range(0, 5) == 0);
        r      = $urandom();  btgt = {r[31:2], 2'b00};
        r      = $urandom();  ftgt = {r[31:2], 2'b00};
        exc    = ($urandom_range(0, 7) == 0);
        r      = $urandom();  et = r[3:0];
        i1     = rsp ? inst_of(ic[0].pc) : 32'h0;
        i2     = rsp ? inst_of(ic[0].pc + 32'd4) : 32'h0;
        cmax   = (m_occ < 2) ? m_occ : 2;
        cons   = do_rst ? 2'd0 : 2'($urandom_range(0, cmax));

        @(negedge clk);
        drive(do_rst, fl, ftgt, rdy, rsp, i1, i2, exc, et, cons, t1, t2, btgt);
        #1;

        ev  = !do_rst && !fl && (m_out < MAX_OUT) && (m_occ + m_res + 2 <= DEPTH);
        esz = 0;
        if (!do_rst && rsp && !fl && m_stale == 0 && m_meta.size() > 0) begin
            hd  = m_meta[0];
            esz = hd.size;
        end
        chk("rnd.req_valid", 32'(bus.req_valid), 32'(ev));
        if (ev) chk("rnd.req_pc", bus.req_pc, m_pc);
        chk("rnd.ibuf_size", 32'(bus.ibuf_input_size), 32'(esz));
        if (esz != 0) begin
            chk("rnd.ibuf_pc1", bus.ibuf_pc1, hd.pc);
            chk("rnd.ibuf_pc2", bus.ibuf_pc2, hd.pc + 32'd4);
            chk("rnd.ibuf_inst1", bus.ibuf_inst1, inst_of(hd.pc));
            chk("rnd.ibuf_inst2", bus.ibuf_inst2, inst_of(hd.pc + 32'd4));
            chk("rnd.pred_taken1", 32'(bus.ibuf_pred_taken1), 32'(hd.t1));
            chk("rnd.pred_taken2", 32'(bus.ibuf_pred_taken2), 32'(hd.t2));
            chk("rnd.pred_target1", bus.ibuf_pred_target1, hd.tgt);
            chk("rnd.pred_target2", bus.ibuf_pred_target2, hd.tgt);
            chk("rnd.have_exc1", 32'(bus.ibuf_have_exception1), 32'(exc));
            chk("rnd.exc_type1", 32'(bus.ibuf_exception_type1), 32'(et));
        end

        @(posedge clk);
        cyc++;
        if (do_rst) begin
            model_reset();
        end else if (fl) begin
            if (rsp) begin
                void'(ic.pop_front());
                m_out--;
            end
            m_stale = m_out;
            m_meta.delete();
            m_occ = 0;
            m_res = 0;
            m_pc  = ftgt;
        end else begin
            acc = ev && rdy;
            if (rsp) begin
                void'(ic.pop_front());
                m_out--;
                if (m_stale > 0) begin
                    m_stale--;
                end else begin
                    m_occ += esz;
                    m_res -= 2;
                    void'(m_meta.pop_front());
                end
            end
            if (acc) begin
                sz = (m_pc[2] || t1) ? 1 : 2;
                nm.pc = m_pc;  nm.size = sz;  nm.t1 = t1;  nm.t2 = t2 && (sz == 2);  nm.tgt = btgt;
                m_meta.push_back(nm);
                ne.pc = m_pc;  ne.due = cyc + $urandom_range(0, 2);
                ic.push_back(ne);
                m_res += 2;
                m_out++;
                if (t1 || (t2 && sz == 2)) m_pc = btgt;
                else                      m_pc = (m_pc & ~32'd7) + 32'd8;
            end
            m_occ -= int'(cons);
        end
    endtask

    vec_t tbl[$];

    initial begin
        int  accepts, occ_t;
        logic prev_acc;

        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h1c000000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h1c000008, 2, 32'h1c000000, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h1c000010, 2, 32'h1c000008, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h1c000018, 2, 32'h1c000010, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 32'h1c000018, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h1c000020, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1c000104, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h1c000104, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h1c000108, 1, 32'h1c000104, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000110, 2, 32'h1c000108, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 32'h1c000400, 1, 32'h1c000110, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h1c000400, 2, 32'h1c000110, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 32'h1c000400, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 32'h1c000800, 1, 32'h1c000408, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h1c000408, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h1c000800, 0, 0, 0, 0));

        reset_cycle("tbl");
        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Flush with two requests in flight, no response in the flush cycle
        reset_cycle("seqA");
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h1c000000, 0, 0, 0, 0), "seqA0");
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h1c000008, 0, 0, 0, 0), "seqA1");
        apply(mk(1, 32'h1c000300, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "seqA2");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "seqA3");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000300, 0, 0, 0, 0), "seqA4");
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h1c000300, 0, 0, 0, 0), "seqA5");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000308, 2, 32'h1c000300, 0, 0), "seqA6");

        // Flush coinciding with a response while two requests are in flight
        reset_cycle("seqB");
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h1c000000, 0, 0, 0, 0), "seqB0");
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h1c000008, 0, 0, 0, 0), "seqB1");
        apply(mk(1, 32'h1c000500, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "seqB2");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000500, 0, 0, 0, 0), "seqB3");
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h1c000500, 0, 0, 0, 0), "seqB4");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000508, 2, 32'h1c000500, 0, 0), "seqB5");

        // Steady stream: 1-cycle icache, decoder drains two per cycle
        reset_cycle("steady");
        accepts  = 0;
        occ_t    = 0;
        prev_acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] cons;
            cons = (occ_t < 2) ? 2'(occ_t) : 2'd2;
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0, 1'b1, prev_acc, 32'h0, 32'h0, 1'b0, 4'h0, cons,
                  1'b0, 1'b0, 32'h0);
            #1;
            chk("steady.req_pc", bus.req_pc, RESET_PC + 32'(8 * i));
            if (prev_acc) chk("steady.ibuf_size", 32'(bus.ibuf_input_size), 32'd2);
            occ_t    = occ_t + (prev_acc ? 2 : 0) - int'(cons);
            prev_acc = bus.req_valid;
            if (bus.req_valid) accepts++;
        end
        chk("steady.accepts", 32'(accepts), 32'd40);

        // Randomized run against the reference model
        reset_cycle("rnd");
        model_reset();
        cyc = 0;
        for (int n = 0; n < 4000; n++) rand_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
